window_3x3_gen: RTL and testbench

- Streaming 3x3 neighbourhood generator. Sits directly upstream of the 3x3 averaging filter.
- Accepts 8-bit grayscale pixels in raster order, one per cycle when valid.
- Buffers the two previous image rows and presents each fully-interior 3x3 window on nine registered 8-bit outputs s1..s9, which map one-to-one onto the filter's s1..s9 inputs.
- Only "valid-mode" windows are emitted: no border padding, so (IMG_W-2)*(IMG_H-2) windows per frame.

---
 rtl/window_3x3_gen_if.sv | 23 ++
 rtl/window_3x3_gen.sv | 121 ++++++++++++
 tb/tb_window_3x3_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/window_3x3_gen_if.sv
// Streaming pixel-in / 3x3-window-out bundle for window_3x3_gen.
// The master side feeds raster-order pixels and observes the window.
// The slave side is the generator.
interface window_3x3_gen_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] pix_in;
  logic [PIX_W-1:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;
  logic             out_valid;
  logic             out_eof;

  modport master (
    output in_valid, in_sof, pix_in,
    input  s1, s2, s3, s4, s5, s6, s7, s8, s9, out_valid, out_eof
  );

  modport slave (
    input  in_valid, in_sof, pix_in,
    output s1, s2, s3, s4, s5, s6, s7, s8, s9, out_valid, out_eof
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator (valid-mode, no border padding).
// Two row line buffers feed the right-hand column of a 3x3 shift window.
// A window is flagged valid only when it lies entirely inside the frame.
module window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  window_3x3_gen_if.slave   bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [RW-1:0]    row_q, row_d, row_eff;
  logic             accept;

  logic [PIX_W-1:0] lb_a [IMG_W];
  logic [PIX_W-1:0] lb_b [IMG_W];
  logic [PIX_W-1:0] rd_a, rd_b;

  // win index 0..8 maps to s1..s9 (row-major, s1 top-left).
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic             out_valid_q, out_valid_d;
  logic             out_eof_q, out_eof_d;

  // Position of the pixel being accepted: start-of-frame overrides the counters.
  always_comb begin
    accept  = bus.in_valid;
    col_eff = bus.in_sof ? '0 : col_q;
    row_eff = bus.in_sof ? '0 : row_q;
  end

  // Read the line buffers before this cycle's write lands.
  assign rd_a = lb_a[col_eff];
  assign rd_b = lb_b[col_eff];

  // Next-state for counters, window shift and output flags.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = 1'b0;
    out_eof_d   = 1'b0;
    if (accept) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end

      // Shift columns left; new right column is top-to-bottom lb_b, lb_a, pix_in.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = rd_b;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = rd_a;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_in;

      // Columns left over from the previous row sit in the window at c < 2,
      // and rows 0-1 read stale line-buffer data; both are gated off here.
      out_valid_d = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
      out_eof_d   = out_valid_d && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end
  end

  // Control and window registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      win_q       <= win_d;
    end
  end

  // Line-buffer write: previous row ages into lb_b, the new pixel into lb_a.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately not reset; row gating keeps its stale contents from ever reaching the outputs.
    if (accept) begin
      lb_b[col_eff] <= rd_a;
      lb_a[col_eff] <= bus.pix_in;
    end
  end

  assign bus.s1        = win_q[0];
  assign bus.s2        = win_q[1];
  assign bus.s3        = win_q[2];
  assign bus.s4        = win_q[3];
  assign bus.s5        = win_q[4];
  assign bus.s6        = win_q[5];
  assign bus.s7        = win_q[6];
  assign bus.s8        = win_q[7];
  assign bus.s9        = win_q[8];
  assign bus.out_valid = out_valid_q;
  assign bus.out_eof   = out_eof_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image (pixel = base + 4*r + c).
module tb_window_3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.PIX_W(8)) bus ();

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses;
  logic [71:0] obs;
  logic [71:0] exp_win;
  logic        have_win;

  assign obs = {bus.s1, bus.s2, bus.s3, bus.s4, bus.s5, bus.s6, bus.s7, bus.s8, bus.s9};

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic sof, input logic [7:0] p);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.pix_in   = p;
    @(posedge clk);
    #1;
  endtask

  // Expected window whose bottom-right pixel is (r,c).
  function automatic logic [71:0] win_at(input int base, input int r, input int c);
    logic [71:0] res;
    res = '0;
    for (int k = 0; k < 9; k++)
      res[71-8*k -: 8] = 8'(base + 4*(r - 2 + k/3) + (c - 2 + k%3));
    return res;
  endfunction

  // Send pixels [first, last) of a frame; optional idle gap after each.
  task automatic send_frame(input int base, input logic sof, input logic gap,
                            input int first, input int last);
    int r, c;
    for (int i = first; i < last; i++) begin
      r = i / W;
      c = i % W;
      step(1'b1, sof && (i == first), 8'(base + 4*r + c));
      if (bus.out_valid) pulses++;
      if (r >= 2 && c >= 2) begin
        exp_win  = win_at(base, r, c);
        have_win = 1'b1;
        check("win", obs, exp_win);
        check("valid", 72'(bus.out_valid), 72'(1));
        check("eof", 72'(bus.out_eof), 72'((r == H-1) && (c == W-1)));
      end else begin
        have_win = 1'b0;
        check("no_valid", 72'(bus.out_valid), 72'(0));
      end
      if (gap) begin
        // in_sof without in_valid must be ignored.
        step(1'b0, 1'b1, 8'hA5);
        check("gap_valid", 72'(bus.out_valid), 72'(0));
        check("gap_eof", 72'(bus.out_eof), 72'(0));
        if (have_win) check("gap_hold", obs, exp_win);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    bus.pix_in   = 8'h77;
    rst_n        = 1'b0;
    have_win     = 1'b0;

    // Test 1: reset values, held 3 cycles with in_valid high.
    #1;
    check("rst_win", obs, '0);
    check("rst_valid", 72'(bus.out_valid), 72'(0));
    check("rst_eof", 72'(bus.out_eof), 72'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hold_win", obs, '0);
      check("rst_hold_valid", 72'(bus.out_valid), 72'(0));
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 2: continuous frame with hand-computed windows.
    pulses = 0;
    send_frame(0, 1'b1, 1'b0, 0, 11);
    check("t2_px10", obs, {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
    send_frame(0, 1'b0, 1'b0, 11, 16);
    check("t2_last", obs, {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15});
    check("t2_last_eof", 72'(bus.out_eof), 72'(1));
    check("t2_pulses", 72'(pulses), 72'(4));

    // Test 3: same frame with idle cycles interleaved.
    pulses = 0;
    send_frame(0, 1'b1, 1'b1, 0, 16);
    check("t3_pulses", 72'(pulses), 72'(4));

    // Test 4: in_sof on the 7th pixel, then a full frame.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check("t4_pre", 72'(bus.out_valid), 72'(0));
    end
    step(1'b1, 1'b1, 8'd6);
    check("t4_sof", 72'(bus.out_valid), 72'(0));
    pulses = 0;
    send_frame(0, 1'b1, 1'b0, 0, 16);
    check("t4_pulses", 72'(pulses), 72'(4));

    // Test 5: asynchronous reset mid-cycle after 11 pixels, then frame without in_sof.
    send_frame(0, 1'b0, 1'b0, 0, 11);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_win", obs, '0);
    check("t5_async_valid", 72'(bus.out_valid), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_rst_win", obs, '0);
    pulses = 0;
    send_frame(0, 1'b0, 1'b0, 0, 16);
    check("t5_pulses", 72'(pulses), 72'(4));

    // Test 6: back-to-back frames, second offset by 100.
    pulses = 0;
    send_frame(0, 1'b1, 1'b0, 0, 16);
    send_frame(100, 1'b1, 1'b0, 0, 11);
    check("t6_first", obs, {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110});
    send_frame(100, 1'b0, 1'b0, 11, 16);
    check("t6_pulses", 72'(pulses), 72'(8));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
